pipeline_stage_regs: RTL
========================

// Module: pipeline_stage_regs
// PURPOSE
//  Holds the F/D/E/M/W pipeline registers of the Y86 pipelined core and applies the stall/bubble
//  commands issued by the pipeline control logic each clock edge. Sits between stage combinational
//  logic (fetch/decode/execute/memory) and the next stage's inputs. Also keeps a sticky control-error flag.
// PARAMETERS
//  DW     64     width of the valC/valP/valA/valB/valE/valM/predPC fields
//  INOP   4'h1   icode injected by a bubble (nop)
//  RNONE  4'hF   register ID injected by a bubble
//  SAOK   3'h1   stat injected by a bubble
// PORTS
//  clk                         in   1   rising-edge clock
//  rst_n                       in   1   asynchronous, active-low reset
//  F_stall,D_stall,W_stall     in   1   hold that stage register
//  D_bubble,E_bubble,M_bubble  in   1   load nop into that stage register
//  f_predPC                    in   DW  next predicted PC from fetch
//  f_stat/f_icode/f_ifun       in   3/4/4   fetch outputs for D
//  f_rA/f_rB, f_valC/f_valP    in   4/4, DW/DW   fetch outputs for D
//  d_stat/icode/ifun           in   3/4/4   decode outputs for E
//  d_valC/valA/valB            in   DW  decode outputs for E
//  d_dstE/dstM/srcA/srcB       in   4   decode outputs for E
//  e_stat/icode, e_Cnd         in   3/4, 1   execute outputs for M
//  e_valE/valA, e_dstE/dstM    in   DW, 4    execute outputs for M
//  m_stat/icode, m_valE/valM   in   3/4, DW  memory outputs for W
//  m_dstE/dstM                 in   4   memory outputs for W
//  F_predPC                    out  DW  registered F stage
//  D_*,E_*,M_*,W_* (same fields as inputs above, upper-case stage prefix)  out  registered stages
//  ctrl_err                    out  1   sticky: D_stall and D_bubble asserted together
// BEHAVIOUR
//  - Reset (rst_n=0, async): F_predPC=0; every D/E/M/W register = bubble value
//    (stat=SAOK, icode=INOP, ifun=0, reg IDs=RNONE, data fields=0, M_Cnd=0); ctrl_err=0.
//  - All updates on rising clk, 1-cycle latency: stage input at edge k visible on outputs after edge k.
//  - F: F_stall=1 -> hold; else load f_predPC.
//  - D: D_stall=1 -> hold; else D_bubble=1 -> bubble; else load f_* fields.
//    D_stall and D_bubble both 1: stall wins (hold), ctrl_err set and held until reset.
//  - E: E_bubble=1 -> bubble; else load d_* fields. No stall input.
//  - M: M_bubble=1 -> bubble; else load e_* fields. No stall input.
//  - W: W_stall=1 -> hold; else load m_* fields. W_stall held indefinitely freezes W (halt/exception).
//  - Each stage decides from its own command only; simultaneous commands on different stages are independent
//    (e.g. load-use: F_stall+D_stall+E_bubble -> F,D hold, E gets nop, M/W advance).
//  - Bubble overwrites all fields of a stage in one edge; no partial update.
//  - Reset asserted mid-operation clears immediately regardless of clk or pending commands;
//    first load occurs on the first rising edge after rst_n rises.
//  - No internal combinational path input->output; outputs are pure flop outputs.
// TESTING
//  1. Reset: rst_n=0 mid-cycle -> all D/E/M/W icode=1, stat=1, reg IDs=F, F_predPC=0, ctrl_err=0 without clk edge.
//  2. Free flow: f_icode=3 (irmovq), f_valC=0x10, no commands -> D_icode=3 after edge1, E after edge2 (from d_*), etc.
//  3. Load-use: D holds icode=6, F_stall=D_stall=E_bubble=1 one cycle -> F_predPC, D_* unchanged, E_icode=1, E_dstE=F.
//  4. Mispredict: D_bubble=E_bubble=1 with f_icode=2, d_icode=6 -> D_icode=1, E_icode=1; M loads e_* normally.
//  5. Exception: W_stall=1 for 5 cycles with m_stat=3 changing -> W_* frozen at prior value; M_bubble=1 -> M_icode=1.
//  6. Illegal: D_stall=D_bubble=1 -> D held, ctrl_err=1 and stays 1 after both drop; cleared only by rst_n=0.

Source files
------------

// File: rtl/pipeline_stage_regs.sv
// F/D/E/M/W pipeline registers of the Y86 pipelined core with per-stage stall/bubble
// handling and a sticky flag for the contradictory D_stall+D_bubble command.
module pipeline_stage_regs #(
   parameter int         DW    = 64,
   parameter logic [3:0] INOP  = 4'h1,
   parameter logic [3:0] RNONE = 4'hF,
   parameter logic [2:0] SAOK  = 3'h1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          F_stall,
   input  logic          D_stall,
   input  logic          W_stall,
   input  logic          D_bubble,
   input  logic          E_bubble,
   input  logic          M_bubble,
   input  logic [DW-1:0] f_predPC,
   input  logic [2:0]    f_stat,
   input  logic [3:0]    f_icode,
   input  logic [3:0]    f_ifun,
   input  logic [3:0]    f_rA,
   input  logic [3:0]    f_rB,
   input  logic [DW-1:0] f_valC,
   input  logic [DW-1:0] f_valP,
   input  logic [2:0]    d_stat,
   input  logic [3:0]    d_icode,
   input  logic [3:0]    d_ifun,
   input  logic [DW-1:0] d_valC,
   input  logic [DW-1:0] d_valA,
   input  logic [DW-1:0] d_valB,
   input  logic [3:0]    d_dstE,
   input  logic [3:0]    d_dstM,
   input  logic [3:0]    d_srcA,
   input  logic [3:0]    d_srcB,
   input  logic [2:0]    e_stat,
   input  logic [3:0]    e_icode,
   input  logic          e_Cnd,
   input  logic [DW-1:0] e_valE,
   input  logic [DW-1:0] e_valA,
   input  logic [3:0]    e_dstE,
   input  logic [3:0]    e_dstM,
   input  logic [2:0]    m_stat,
   input  logic [3:0]    m_icode,
   input  logic [DW-1:0] m_valE,
   input  logic [DW-1:0] m_valM,
   input  logic [3:0]    m_dstE,
   input  logic [3:0]    m_dstM,
   output logic [DW-1:0] F_predPC,
   output logic [2:0]    D_stat,
   output logic [3:0]    D_icode,
   output logic [3:0]    D_ifun,
   output logic [3:0]    D_rA,
   output logic [3:0]    D_rB,
   output logic [DW-1:0] D_valC,
   output logic [DW-1:0] D_valP,
   output logic [2:0]    E_stat,
   output logic [3:0]    E_icode,
   output logic [3:0]    E_ifun,
   output logic [DW-1:0] E_valC,
   output logic [DW-1:0] E_valA,
   output logic [DW-1:0] E_valB,
   output logic [3:0]    E_dstE,
   output logic [3:0]    E_dstM,
   output logic [3:0]    E_srcA,
   output logic [3:0]    E_srcB,
   output logic [2:0]    M_stat,
   output logic [3:0]    M_icode,
   output logic          M_Cnd,
   output logic [DW-1:0] M_valE,
   output logic [DW-1:0] M_valA,
   output logic [3:0]    M_dstE,
   output logic [3:0]    M_dstM,
   output logic [2:0]    W_stat,
   output logic [3:0]    W_icode,
   output logic [DW-1:0] W_valE,
   output logic [DW-1:0] W_valM,
   output logic [3:0]    W_dstE,
   output logic [3:0]    W_dstM,
   output logic          ctrl_err
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        F_predPC <= '0;
      else if (!F_stall) F_predPC <= f_predPC;
   end

   // stall has priority over bubble when both are (illegally) requested
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         D_stat <= SAOK;  D_icode <= INOP; D_ifun <= '0;
         D_rA   <= RNONE; D_rB    <= RNONE;
         D_valC <= '0;    D_valP  <= '0;
      end else if (!D_stall) begin
         if (D_bubble) begin
            D_stat <= SAOK;  D_icode <= INOP; D_ifun <= '0;
            D_rA   <= RNONE; D_rB    <= RNONE;
            D_valC <= '0;    D_valP  <= '0;
         end else begin
            D_stat <= f_stat; D_icode <= f_icode; D_ifun <= f_ifun;
            D_rA   <= f_rA;   D_rB    <= f_rB;
            D_valC <= f_valC; D_valP  <= f_valP;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                   ctrl_err <= 1'b0;
      else if (D_stall && D_bubble) ctrl_err <= 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n || E_bubble) begin
         E_stat <= SAOK;  E_icode <= INOP;  E_ifun <= '0;
         E_valC <= '0;    E_valA  <= '0;    E_valB <= '0;
         E_dstE <= RNONE; E_dstM  <= RNONE; E_srcA <= RNONE; E_srcB <= RNONE;
      end else begin
         E_stat <= d_stat; E_icode <= d_icode; E_ifun <= d_ifun;
         E_valC <= d_valC; E_valA  <= d_valA;  E_valB <= d_valB;
         E_dstE <= d_dstE; E_dstM  <= d_dstM;  E_srcA <= d_srcA; E_srcB <= d_srcB;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n || M_bubble) begin
         M_stat <= SAOK; M_icode <= INOP; M_Cnd  <= 1'b0;
         M_valE <= '0;   M_valA  <= '0;
         M_dstE <= RNONE; M_dstM <= RNONE;
      end else begin
         M_stat <= e_stat; M_icode <= e_icode; M_Cnd  <= e_Cnd;
         M_valE <= e_valE; M_valA  <= e_valA;
         M_dstE <= e_dstE; M_dstM  <= e_dstM;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         W_stat <= SAOK;  W_icode <= INOP;
         W_valE <= '0;    W_valM  <= '0;
         W_dstE <= RNONE; W_dstM  <= RNONE;
      end else if (!W_stall) begin
         W_stat <= m_stat; W_icode <= m_icode;
         W_valE <= m_valE; W_valM  <= m_valM;
         W_dstE <= m_dstE; W_dstM  <= m_dstM;
      end
   end

endmodule
